// File: rtl/autotest_pkg.sv
// Shared types and constants for the autotest harness result path.
package autotest_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET_UUT,
    RUN,
    SEND,
    DONE
  } packer_state_t;

  localparam logic [7:0]  STATUS_OK      = 8'h00;
  localparam logic [7:0]  STATUS_TIMEOUT = 8'hFF;
  localparam int unsigned COUNT_BYTES    = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchronizer for a single asynchronous input, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uut_result_packer.sv
// Releases the UUT from reset, times it until completion or timeout, then
// streams {count, result, status} as a byte record over valid/ready.
module uut_result_packer
  import autotest_pkg::*;
#(
  parameter int unsigned OUTPUT_SIZE    = 32,
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   rst_uut,
  input  logic                   end_uut,
  input  logic [OUTPUT_SIZE-1:0] output_from_UUT,
  output logic [7:0]             byte_data,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned RESULT_BYTES = OUTPUT_SIZE / 8;
  localparam int unsigned NB           = COUNT_BYTES + RESULT_BYTES + 1;
  localparam int unsigned IDX_W        = $clog2(NB);
  localparam int unsigned REC_W        = 8 * NB;

  localparam logic [31:0]      RST_LAST     = 32'(RST_CYCLES - 1);
  localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NB - 1);
  localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);

  packer_state_t state, next_state;

  logic [31:0]            cnt;
  logic [31:0]            count_reg;
  logic [OUTPUT_SIZE-1:0] result_reg;
  logic [7:0]             status_reg;
  logic [IDX_W-1:0]       idx;
  logic                   s2;
  logic                   s2_d;
  logic                   end_edge;
  logic                   timeout_hit;
  logic [REC_W-1:0]       record;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (end_uut),
    .q   (s2)
  );

  assign end_edge    = s2 & ~s2_d;
  assign timeout_hit = (cnt == TIMEOUT_LAST);
  assign record      = {count_reg, result_reg, status_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    rst_uut    = 1'b1;
    byte_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = RESET_UUT;
      end
      RESET_UUT: begin
        if (cnt == RST_LAST) next_state = RUN;
      end
      RUN: begin
        rst_uut = 1'b0;
        if (end_edge || timeout_hit) next_state = SEND;
      end
      SEND: begin
        byte_valid = 1'b1;
        if (byte_ready && (idx == LAST_IDX)) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Record bytes go out MSB first; byte_data idles at zero outside SEND.
  always_comb begin
    byte_data = '0;
    if (state == SEND) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (idx == IDX_W'(i)) byte_data = record[8*(NB-1-i) +: 8];
      end
    end
  end

  // One counter serves both the reset hold and the run timer; it is
  // cleared on the RESET_UUT->RUN transition so RUN starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      count_reg  <= '0;
      result_reg <= '0;
      status_reg <= STATUS_OK;
      s2_d       <= 1'b0;
    end else begin
      s2_d <= s2;
      case (state)
        IDLE: cnt <= '0;
        RESET_UUT: begin
          if (cnt == RST_LAST) cnt <= '0;
          else                 cnt <= cnt + 32'd1;
        end
        RUN: begin
          cnt <= cnt + 32'd1;
          if (end_edge || timeout_hit) begin
            count_reg  <= cnt;
            result_reg <= output_from_UUT;
            status_reg <= end_edge ? STATUS_OK : STATUS_TIMEOUT;
            idx        <= '0;
          end
        end
        SEND: begin
          if (byte_ready && (idx != LAST_IDX)) idx <= idx + IDX_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uut_result_packer.sv
// Randomized self-checking bench for uut_result_packer against a record-level model.
module tb_uut_result_packer;

  localparam int unsigned OS    = 32;
  localparam int unsigned RC    = 4;
  localparam int unsigned TO    = 1000;
  localparam int unsigned NB    = 9;
  localparam int          NEVER = 100000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rst_uut;
  logic        end_uut;
  logic [31:0] output_from_UUT;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_q[$];
  int unsigned exp_count;

  always #5 clk = ~clk;

  uut_result_packer #(
    .OUTPUT_SIZE    (OS),
    .RST_CYCLES     (RC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .rst_uut         (rst_uut),
    .end_uut         (end_uut),
    .output_from_UUT (output_from_UUT),
    .byte_data       (byte_data),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .busy            (busy),
    .done            (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected record: edge detected two cycles after the raise, unless the
  // deadline at TO-1 comes first (a tie goes to the edge).
  task automatic model(input int k, input bit stuck, input logic [31:0] res);
    logic [7:0] st;
    if (stuck || (k + 2 > int'(TO) - 1)) begin
      exp_count = TO - 1;
      st        = 8'hFF;
    end else begin
      exp_count = k + 2;
      st        = 8'h00;
    end
    exp_q.delete();
    for (int i = 3; i >= 0; i--) exp_q.push_back(8'((exp_count >> (8 * i)) & 32'hFF));
    for (int i = 3; i >= 0; i--) exp_q.push_back(8'((res >> (8 * i)) & 32'hFF));
    exp_q.push_back(st);
  endtask

  // ready_mode: 0 = always ready, 1 = toggle each cycle, 2 = random
  task automatic run_record(input string name, input int k, input bit stuck,
                            input logic [31:0] res, input int ready_mode,
                            input bit start_in_send, input int abort_after);
    int         c, guard, rcycles, sent, send_cycles;
    logic [7:0] got_q[$];
    bit         stalled, stable_ok;
    logic [7:0] stall_byte;

    model(k, stuck, res);
    end_uut         = stuck;
    output_from_UUT = res;
    byte_ready      = (ready_mode != 1);
    start           = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    rcycles = 0; guard = 0;
    @(negedge clk);
    while (rst_uut && guard < 100) begin
      rcycles++; guard++;
      @(negedge clk);
    end
    check({name, "/rst_uut_cycles"}, rcycles, RC);

    c = 0; guard = 0;
    while (!byte_valid && guard < 2 * int'(TO)) begin
      @(posedge clk); #1;
      c++; guard++;
      if (!stuck && c == k) end_uut = 1'b1;
      @(negedge clk);
    end
    check({name, "/first_valid_cycle"}, c, exp_count + 1);
    check({name, "/rst_uut_in_send"}, rst_uut, 1'b1);

    sent = 0; send_cycles = 0; guard = 0; stalled = 0; stable_ok = 1; stall_byte = '0;
    while (!done && guard < 200) begin
      if (byte_valid) begin
        if (stalled && byte_data !== stall_byte) stable_ok = 0;
        if (byte_ready) begin
          got_q.push_back(byte_data);
          sent++;
          stalled = 0;
        end else begin
          stalled    = 1;
          stall_byte = byte_data;
        end
        send_cycles++;
      end
      if (abort_after >= 0 && sent == abort_after) break;
      @(posedge clk); #1;
      guard++;
      start = start_in_send && (send_cycles == 1);
      case (ready_mode)
        1:       byte_ready = ~byte_ready;
        2:       byte_ready = 1'($urandom_range(0, 1));
        default: byte_ready = 1'b1;
      endcase
      @(negedge clk);
    end
    start = 1'b0;

    if (abort_after >= 0) begin
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check({name, "/abort_valid"}, byte_valid, 1'b0);
      check({name, "/abort_busy"}, busy, 1'b0);
      check({name, "/abort_rst_uut"}, rst_uut, 1'b1);
      check({name, "/abort_done"}, done, 1'b0);
      check({name, "/abort_data"}, byte_data, 8'h00);
      @(posedge clk); #1;
      rst = 1'b0;
      return;
    end

    check({name, "/done_seen"}, done, 1'b1);
    check({name, "/valid_in_done"}, byte_valid, 1'b0);
    check({name, "/nbytes"}, got_q.size(), NB);
    for (int i = 0; i < int'(NB); i++)
      check($sformatf("%s/byte%0d", name, i),
            (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
    if (ready_mode == 0) check({name, "/send_cycles"}, send_cycles, NB);
    else                 check({name, "/stall_stable"}, stable_ok, 1'b1);
    @(negedge clk);
    check({name, "/done_one_cycle"}, done, 1'b0);
    check({name, "/busy_after"}, busy, 1'b0);
    @(negedge clk);
    check({name, "/idle_after"}, busy, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst             = 1'b1;
    start           = 1'b0;
    end_uut         = 1'b0;
    byte_ready      = 1'b1;
    output_from_UUT = '0;
    #3;
    check("reset/rst_uut", rst_uut, 1'b1);
    check("reset/byte_valid", byte_valid, 1'b0);
    check("reset/byte_data", byte_data, 8'h00);
    check("reset/busy", busy, 1'b0);
    check("reset/done", done, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run_record("normal", 10, 1'b0, 32'hDEADBEEF, 0, 1'b0, -1);
    run_record("timeout", NEVER, 1'b0, 32'h12345678, 0, 1'b0, -1);
    run_record("backpressure", 20, 1'b0, $urandom, 1, 1'b0, -1);
    run_record("stuck", NEVER, 1'b1, 32'hA5A55A5A, 0, 1'b1, -1);
    run_record("abort", 5, 1'b0, 32'hCAFEF00D, 0, 1'b0, 3);
    run_record("fresh", 7, 1'b0, 32'h0BADC0DE, 0, 1'b0, -1);
    run_record("deadline", 997, 1'b0, 32'h87654321, 0, 1'b0, -1);
    for (int r = 0; r < 4; r++)
      run_record($sformatf("rand%0d", r), int'($urandom_range(1, 60)), 1'b0,
                 $urandom, 2, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uut_result_packer.md
# uut_result_packer

Measurement and result-formatting stage between the unit under test and the SD-card writer path of the autotest harness. It releases the UUT from reset and counts system-clock cycles until the UUT signals completion, or until a timeout. It captures the UUT result and streams a fixed-length byte record (cycle count, result, status) over a valid/ready byte interface to the SD block-write sequencer.

## Interface
- `OUTPUT_SIZE`, 32: UUT result width in bits; must be a multiple of 8.
- `RST_CYCLES`, 16: number of `clk` cycles `rst_uut` is held high after `start`; must be ≥1.
- `TIMEOUT_CYCLES`, 2**24: abort threshold in `clk` cycles; must be ≥2 and < 2**32.
- `clk` input 1: system clock; the block's only clock.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: begin one measurement; sampled only in IDLE.
- `rst_uut` output 1: UUT reset, active-high.
- `end_uut` input 1: UUT completion flag; asynchronous, synchronized internally.
- `output_from_UUT` input OUTPUT_SIZE: UUT result.
- `byte_data` output 8: record byte.
- `byte_valid` output 1: `byte_data` is valid.
- `byte_ready` input 1: consumer accepts the byte this cycle.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after the last record byte is accepted.

## Operation
- Reset values: `rst_uut`=1, `byte_data`=0, `byte_valid`=0, `busy`=0, `done`=0; FSM in IDLE; counter and synchronizer cleared.
- States and transitions:
  - IDLE: `rst_uut`=1. `start`=1 → RESET_UUT. `start` in any other state is ignored.
  - RESET_UUT: `rst_uut`=1 for exactly RST_CYCLES cycles, then → RUN with counter cleared to 0.
  - RUN: `rst_uut`=0. The counter is 0 in the first RUN cycle and increments by 1 in each following cycle.
    - Rising edge of the synchronized `end_uut` (`s2`=1 and previous `s2`=0): in that cycle, latch counter into the count register, latch `output_from_UUT`, set status to STATUS_OK, → SEND.
    - Otherwise, if counter == TIMEOUT_CYCLES-1: latch counter and `output_from_UUT`, set status to STATUS_TIMEOUT, → SEND.
    - If both conditions occur in the same cycle, the edge wins and status is OK.
  - SEND: `rst_uut`=1. Emits NB = 4 + OUTPUT_SIZE/8 + 1 bytes, in this order:
    - count, 32 bits, MSB first;
    - result, MSB first;
    - status byte.
  - After the handshake on the last byte → DONE.
  - DONE: `done`=1 for one cycle, then → IDLE.
- `end_uut` already high when RUN begins produces no rising edge. Such a run ends by timeout.
- Counter is 32 bits. It cannot wrap, because TIMEOUT_CYCLES < 2**32.

## Timing
- Synchronizer: two flops on `end_uut`, followed by an edge-detect flop. If `end_uut` rises at the edge that begins RUN cycle k, detection happens in cycle k+2 and the captured count is k+2.
- Latency from `start` sampled in IDLE:
  - `rst_uut` stays high in RESET_UUT through cycles 1..RST_CYCLES;
  - `rst_uut` falls at the start of cycle RST_CYCLES+1.
- The first `byte_valid` is asserted in the cycle after capture.
- Handshake:
  - A byte transfers on `byte_valid && byte_ready` at a rising edge.
  - `byte_data` is held stable while `byte_valid && !byte_ready`.
  - With `byte_ready` held at 1, the byte stream runs back-to-back at one byte per cycle.
  - `byte_valid` drops in the cycle after the last transfer, which is the DONE cycle.
- Reset mid-operation: every output returns to its reset value immediately; any partial record is discarded.

## Structure
- Package `autotest_pkg`:
  - `packer_state_t` enum (IDLE, RESET_UUT, RUN, SEND, DONE);
  - `STATUS_OK` = 8'h00;
  - `STATUS_TIMEOUT` = 8'hFF;
  - `COUNT_BYTES` = 4.
- Sub-module `sync_2ff`: two-flop level synchronizer with asynchronous reset to 0. The single FSM, counter, capture registers and byte mux stay in the top module.

## Test plan
All scenarios use OUTPUT_SIZE=32, RST_CYCLES=4, TIMEOUT_CYCLES=1000.
1. **Normal run:** pulse `start`; `end_uut` rises at RUN cycle 10; `output_from_UUT`=32'hDEADBEEF, `byte_ready`=1 → `rst_uut` is high for 4 cycles. Bytes are 00 00 00 0C DE AD BE EF 00 on consecutive cycles, then one `done` pulse.
2. **Timeout:** `end_uut` held at 0 → capture at counter 999. Bytes are 00 00 03 E7, then result, then FF.
3. **Backpressure:** `byte_ready` toggles every cycle → 9 bytes in order, none dropped or duplicated. `byte_data` is stable throughout every stall.
4. **Stuck completion flag:** `end_uut` is already 1 on RUN entry → record ends by timeout with status FF. A second `start` pulse during SEND has no effect.
5. **Reset mid-SEND:** assert `rst` after 3 bytes → `byte_valid`=0, `busy`=0 and `rst_uut`=1 immediately. The next `start` yields a complete fresh 9-byte record.
6. **Edge at the deadline:** the synchronized edge arrives exactly when counter=999 → status 00 and count 999.
